alu4_seq_ctrl: RTL and testbench

Operation sequencer and result register stage that sits directly upstream of the chip-level pin mapping of the 4-bit ALU project. It accepts an opcode and two 4-bit operands on a start strobe and runs the operation. Single-cycle ops finish in one cycle; multiply uses a 4-iteration shift-add engine. It then presents a registered 8-bit result, status flags and a one-cycle done pulse. The top level maps ui_in, uo_out and uio onto these ports.

---
 rtl/alu4_seq_if.sv | 27 ++
 rtl/alu4_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_alu4_seq_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu4_seq_if.sv
// Request/response bundle between the pin-mapping top level and the ALU sequencer.
// The master drives the request side and the slave returns the result and status.
interface alu4_seq_if #(
   parameter int W = 4
);
   logic           ena;
   logic           start;
   logic [2:0]     op;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] result;
   logic           carry;
   logic           zero;
   logic           ovf;

   modport master (
      output ena, start, op, a, b,
      input  busy, done, result, carry, zero, ovf
   );

   modport slave (
      input  ena, start, op, a, b,
      output busy, done, result, carry, zero, ovf
   );
endinterface

// File: rtl/alu4_seq_ctrl.sv
// Operation sequencer for the 4-bit ALU: single-cycle ops finish in EXEC, MUL runs a
// shift-add loop; result/flags are registered and announced with a one-cycle done pulse.
module alu4_seq_ctrl #(
   parameter int W         = 4,
   parameter int MUL_ITERS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   alu4_seq_if.slave   bus
);
   localparam int RW = 2 * W;
   localparam int CW = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_CMP = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

   state_t         state_q, state_d;
   logic [2:0]     op_q, op_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [RW-1:0]  acc_q, acc_d;
   logic [RW-1:0]  mcand_q, mcand_d;
   logic [RW-1:0]  result_q, result_d;
   logic           carry_q, carry_d;
   logic           zero_q, zero_d;
   logic           ovf_q, ovf_d;
   logic           done_q, done_d;

   logic [W:0]     sum_v;
   logic [W-1:0]   diff_v;
   logic [RW-1:0]  alu_res;
   logic           alu_carry;
   logic           alu_ovf;
   logic [RW-1:0]  mul_acc_v;

   // Single-cycle datapath works only on the latched operands.
   always_comb begin
      sum_v     = {1'b0, a_q} + {1'b0, b_q};
      diff_v    = a_q - b_q;
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (op_q)
         OP_ADD: begin
            alu_res   = {{(W-1){1'b0}}, sum_v};
            alu_carry = sum_v[W];
            alu_ovf   = (a_q[W-1] == b_q[W-1]) && (sum_v[W-1] != a_q[W-1]);
         end
         OP_SUB: begin
            alu_res   = {{W{1'b0}}, diff_v};
            alu_carry = (a_q < b_q);
            alu_ovf   = (a_q[W-1] != b_q[W-1]) && (diff_v[W-1] != a_q[W-1]);
         end
         OP_AND:  alu_res = {{W{1'b0}}, a_q & b_q};
         OP_OR:   alu_res = {{W{1'b0}}, a_q | b_q};
         OP_XOR:  alu_res = {{W{1'b0}}, a_q ^ b_q};
         OP_SHL:  alu_res = {{W{1'b0}}, a_q} << b_q[2:0];
         OP_CMP:  alu_res = {{(RW-3){1'b0}}, (a_q > b_q), (a_q == b_q), (a_q < b_q)};
         default: alu_res = '0;
      endcase
   end

   // MUL consumes b_q one bit per iteration while the multiplicand shifts left.
   assign mul_acc_v = acc_q + (b_q[0] ? mcand_q : '0);

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      result_d = result_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               op_d    = bus.op;
               a_d     = bus.a;
               b_d     = bus.b;
               cnt_d   = '0;
               acc_d   = '0;
               mcand_d = {{W{1'b0}}, bus.a};
               state_d = (bus.op == OP_MUL) ? S_MUL : S_EXEC;
            end
         end
         S_EXEC: begin
            result_d = alu_res;
            carry_d  = alu_carry;
            ovf_d    = alu_ovf;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
            state_d  = S_IDLE;
         end
         S_MUL: begin
            acc_d   = mul_acc_v;
            mcand_d = mcand_q << 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(MUL_ITERS - 1)) begin
               result_d = mul_acc_v;
               carry_d  = 1'b0;
               ovf_d    = 1'b0;
               zero_d   = (mul_acc_v == '0);
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else if (bus.ena) begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy   = (state_q != S_IDLE);
   assign bus.done   = done_q & bus.ena;
   assign bus.result = result_q;
   assign bus.carry  = carry_q;
   assign bus.zero   = zero_q;
   assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_alu4_seq_ctrl.sv
// Randomized self-checking bench for alu4_seq_ctrl against an arithmetic reference model;
// inputs change and outputs are sampled on the falling clock edge.
module tb_alu4_seq_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] last_res = 8'h00;

   alu4_seq_if #(.W(4)) bus ();

   alu4_seq_ctrl #(.W(4), .MUL_ITERS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Returns {ovf, carry, result[7:0]} from plain integer arithmetic.
   function automatic logic [9:0] ref_model(input int op, input int a, input int b);
      int r, s, sa, sb;
      logic c, o;
      sa = (a > 7) ? a - 16 : a;
      sb = (b > 7) ? b - 16 : b;
      c = 1'b0;
      o = 1'b0;
      case (op)
         0: begin r = a + b; c = (r > 15); s = sa + sb; o = (s > 7) || (s < -8); end
         1: begin r = (a - b + 16) % 16; c = (a < b); s = sa - sb; o = (s > 7) || (s < -8); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = (a * (1 << (b % 8))) % 256;
         6: r = a * b;
         default: r = ((a > b) ? 4 : 0) + ((a == b) ? 2 : 0) + ((a < b) ? 1 : 0);
      endcase
      return {o, c, 8'(r)};
   endfunction

   task automatic run_op(input int op_v, input int a_v, input int b_v,
                         input int pause_at, input int pause_len, input bit spam);
      logic [9:0] e;
      int n, elapsed, lat;
      e = ref_model(op_v, a_v, b_v);
      lat = ((op_v == 6) ? 5 : 2) + ((pause_at > 0) ? pause_len : 0);
      bus.ena   = 1'b1;
      bus.op    = 3'(op_v);
      bus.a     = 4'(a_v);
      bus.b     = 4'(b_v);
      bus.start = 1'b1;
      tick();
      n = 1;
      elapsed = 1;
      bus.start = 1'b0;
      bus.op    = 3'($urandom_range(0, 7));
      bus.a     = 4'($urandom_range(0, 15));
      bus.b     = 4'($urandom_range(0, 15));
      while (!bus.done && n < 30) begin
         check("busy", bus.busy, 1);
         check("hold", bus.result, last_res);
         if (spam && n == 1) bus.start = 1'b1;
         if (n == pause_at) begin
            bus.ena = 1'b0;
            repeat (pause_len) begin
               tick();
               elapsed++;
               check("paused_done", bus.done, 0);
            end
            bus.ena = 1'b1;
         end
         tick();
         bus.start = 1'b0;
         n++;
         elapsed++;
      end
      check("done_seen", bus.done, 1);
      check("latency", elapsed, lat);
      check("result", bus.result, e[7:0]);
      check("carry", bus.carry, e[8]);
      check("ovf", bus.ovf, e[9]);
      check("zero", bus.zero, (e[7:0] == 8'h00));
      check("busy_end", bus.busy, 0);
      last_res = e[7:0];
      $display("op=%0d a=0x%0h b=0x%0h result=0x%02h carry=%0b ovf=%0b zero=%0b cycles=%0d",
               op_v, a_v, b_v, bus.result, bus.carry, bus.ovf, bus.zero, elapsed);
      tick();
      check("done_pulse", bus.done, 0);
      check("hold_after", bus.result, last_res);
   endtask

   initial begin
      int op_r, base, pa, pl;
      rst_n     = 1'b0;
      bus.ena   = 1'b1;
      bus.start = 1'b0;
      bus.op    = 3'd0;
      bus.a     = 4'd0;
      bus.b     = 4'd0;
      repeat (2) tick();
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_result", bus.result, 0);
      check("rst_carry", bus.carry, 0);
      check("rst_zero", bus.zero, 0);
      check("rst_ovf", bus.ovf, 0);
      rst_n = 1'b1;
      tick();

      run_op(0, 9, 8, 0, 0, 0);
      run_op(1, 3, 5, 0, 0, 0);
      run_op(4, 10, 10, 0, 0, 0);
      run_op(6, 15, 15, 0, 0, 0);
      run_op(6, 0, 7, 0, 0, 0);
      run_op(7, 7, 7, 0, 0, 0);
      run_op(5, 15, 3, 0, 0, 0);
      run_op(6, 5, 9, 0, 0, 1);

      // Back-to-back: second start held in the done cycle of the first.
      bus.op = 3'd0; bus.a = 4'd5; bus.b = 4'd6; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      check("b2b_done1", bus.done, 1);
      check("b2b_res1", bus.result, 8'h0B);
      bus.op = 3'd2; bus.a = 4'hC; bus.b = 4'hA; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("b2b_gap", bus.done, 0);
      tick();
      check("b2b_done2", bus.done, 1);
      check("b2b_res2", bus.result, 8'h08);
      $display("op=2 back-to-back result=0x%02h", bus.result);
      last_res = 8'h08;
      tick();

      run_op(6, 6, 7, 2, 3, 0);

      // Reset during MUL iteration 2.
      bus.op = 3'd6; bus.a = 4'hD; bus.b = 4'hB; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (2) tick();
      #2 rst_n = 1'b0;
      #1;
      check("abort_result", bus.result, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_carry", bus.carry, 0);
      $display("reset during MUL result=0x%02h busy=%0b", bus.result, bus.busy);
      tick();
      rst_n = 1'b1;
      last_res = 8'h00;
      repeat (8) begin
         tick();
         check("post_rst_done", bus.done, 0);
         check("post_rst_busy", bus.busy, 0);
      end

      for (int i = 0; i < 40; i++) begin
         op_r = $urandom_range(0, 7);
         base = (op_r == 6) ? 5 : 2;
         pa = 0;
         pl = 0;
         if ($urandom_range(0, 3) == 0) begin
            pa = $urandom_range(1, base - 1);
            pl = $urandom_range(1, 4);
         end
         run_op(op_r, $urandom_range(0, 15), $urandom_range(0, 15), pa, pl,
                1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
